i2c_write_sequencer: RTL and testbench

Transaction-level controller that sits between the CPU register interface and the I2C bit engine `i2cUnit`. It accepts a whole write transfer (7-bit slave address plus N data bytes, buffered in a small FIFO) and sequences the engine's primitive commands: START, TX address, TX each byte, STOP. It generates the engine's `cycleDone` bus-phase tick, checks every ACK bit, and reports completion, byte count and NACK errors.

---
 rtl/i2c_pkg.sv | 23 ++
 rtl/i2c_tx_fifo.sv | 46 ++++
 rtl/i2c_write_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_i2c_write_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C write sequencer: engine command codes, ACK levels and FSM states.
package i2c_pkg;

  localparam logic [1:0] I2C_CMD_START = 2'b00;
  localparam logic [1:0] I2C_CMD_STOP  = 2'b01;
  localparam logic [1:0] I2C_CMD_TX    = 2'b10;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  typedef enum logic [3:0] {
    StIdle,
    StIssueStart,
    StWaitStart,
    StIssueAddr,
    StWaitAddr,
    StIssueData,
    StWaitData,
    StIssueStop,
    StWaitStop
  } seq_state_e;

endpackage

// File: rtl/i2c_tx_fifo.sv
// Synchronous write-data FIFO; pointers carry one extra wrap bit to separate full from empty.
module i2c_tx_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  output logic             push_ready_o,
  input  logic             pop_i,
  output logic [Width-1:0] pop_data_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] PtrOne = 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW:0]    wr_ptr_q, rd_ptr_q;
  logic             full, do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                   (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees a slot, so a full FIFO can still take a push.
  assign push_ready_o = !full || do_pop;
  assign do_push      = push_i && push_ready_o;
  assign pop_data_o   = mem_q[rd_ptr_q[PtrW-1:0]];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[PtrW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/i2c_write_sequencer.sv
// Sequences START / TX address / TX data bytes / STOP on the I2C bit engine for one write transfer,
// generating the bus-phase tick and checking every ACK.
module i2c_write_sequencer
  import i2c_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] clocksPerCycle,
  input  logic        xferStart,
  input  logic        xferAbort,
  input  logic [6:0]  slaveAddr,
  input  logic [7:0]  byteCount,
  input  logic [7:0]  wrData,
  input  logic        wrValid,
  output logic        wrReady,
  output logic        busy,
  output logic        done,
  output logic        nackError,
  output logic [7:0]  bytesSent,
  output logic        cycleDone,
  output logic [1:0]  i2cCommand,
  output logic [7:0]  i2cWriteData,
  output logic        i2cTransactionValid,
  input  logic        i2cBusy,
  input  logic        i2cWriteAck,
  input  logic [7:0]  i2cReadData,
  input  logic        i2cReadDataValid
);

  seq_state_e  state_q, state_d;
  logic [6:0]  addr_q, addr_d;
  logic [7:0]  remaining_q, remaining_d;
  logic [7:0]  bytes_sent_q, bytes_sent_d;
  logic        nack_q, nack_d;
  logic [15:0] tick_cnt_q, tick_cnt_d;
  logic [15:0] tick_last_q, tick_last_d;
  logic [15:0] cpc_last;
  logic        tick, accept, fifo_pop, fifo_empty, ack_bit;
  logic [7:0]  fifo_head;
  logic        unused_read_data;

  assign unused_read_data = ^i2cReadData[7:1];
  assign ack_bit          = i2cReadData[0];

  // The period is only reloaded at the wrap so a mid-period change never shortens a phase.
  assign cpc_last = (clocksPerCycle == 16'd0) ? 16'd0 : clocksPerCycle - 16'd1;
  assign tick     = (tick_cnt_q >= tick_last_q);

  always_comb begin
    tick_cnt_d  = tick_cnt_q + 16'd1;
    tick_last_d = tick_last_q;
    if (tick) begin
      tick_cnt_d  = 16'd0;
      tick_last_d = cpc_last;
    end
  end

  assign cycleDone = tick;
  assign accept    = i2cTransactionValid && tick && !i2cBusy;
  assign fifo_pop  = (state_q == StIssueData) && i2cWriteAck;

  i2c_tx_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (8)
  ) u_fifo (
    .clk_i        (clk),
    .reset_i      (reset),
    .push_i       (wrValid),
    .push_data_i  (wrData),
    .push_ready_o (wrReady),
    .pop_i        (fifo_pop),
    .pop_data_o   (fifo_head),
    .empty_o      (fifo_empty)
  );

  always_comb begin
    state_d             = state_q;
    addr_d              = addr_q;
    remaining_d         = remaining_q;
    bytes_sent_d        = bytes_sent_q;
    nack_d              = nack_q;
    i2cTransactionValid = 1'b0;
    i2cCommand          = I2C_CMD_START;
    i2cWriteData        = 8'h00;
    done                = 1'b0;

    if (fifo_pop) remaining_d = remaining_q - 8'd1;

    unique case (state_q)
      StIdle: begin
        if (xferStart) begin
          state_d      = StIssueStart;
          addr_d       = slaveAddr;
          remaining_d  = byteCount;
          bytes_sent_d = 8'd0;
          nack_d       = 1'b0;
        end
      end
      StIssueStart: begin
        i2cTransactionValid = 1'b1;
        i2cCommand          = I2C_CMD_START;
        if (accept) state_d = StWaitStart;
      end
      StWaitStart: begin
        if (!i2cBusy) state_d = xferAbort ? StIssueStop : StIssueAddr;
      end
      StIssueAddr: begin
        i2cTransactionValid = 1'b1;
        i2cCommand          = I2C_CMD_TX;
        i2cWriteData        = {addr_q, 1'b0};
        if (accept) state_d = StWaitAddr;
      end
      StWaitAddr: begin
        if (i2cReadDataValid && ack_bit == I2C_NACK) begin
          nack_d  = 1'b1;
          state_d = StIssueStop;
        end else if (!i2cBusy) begin
          state_d = (xferAbort || remaining_q == 8'd0) ? StIssueStop : StIssueData;
        end
      end
      StIssueData: begin
        i2cCommand = I2C_CMD_TX;
        if (fifo_empty) begin
          // Underrun: the engine holds SCL low until a byte arrives or we give up.
          if (xferAbort) state_d = StIssueStop;
        end else begin
          i2cTransactionValid = 1'b1;
          i2cWriteData        = fifo_head;
          if (accept) state_d = StWaitData;
        end
      end
      StWaitData: begin
        if (i2cReadDataValid && ack_bit == I2C_NACK) begin
          nack_d  = 1'b1;
          state_d = StIssueStop;
        end else begin
          if (i2cReadDataValid) bytes_sent_d = bytes_sent_q + 8'd1;
          if (!i2cBusy) begin
            state_d = (xferAbort || remaining_q == 8'd0) ? StIssueStop : StIssueData;
          end
        end
      end
      StIssueStop: begin
        i2cTransactionValid = 1'b1;
        i2cCommand          = I2C_CMD_STOP;
        if (accept) state_d = StWaitStop;
      end
      StWaitStop: begin
        if (!i2cBusy) begin
          done    = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      addr_q       <= 7'd0;
      remaining_q  <= 8'd0;
      bytes_sent_q <= 8'd0;
      nack_q       <= 1'b0;
      tick_cnt_q   <= 16'd0;
      tick_last_q  <= cpc_last;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      remaining_q  <= remaining_d;
      bytes_sent_q <= bytes_sent_d;
      nack_q       <= nack_d;
      tick_cnt_q   <= tick_cnt_d;
      tick_last_q  <= tick_last_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign nackError = nack_q;
  assign bytesSent = bytes_sent_q;

endmodule

// File: tb/tb_i2c_write_sequencer.sv
// Bench for i2c_write_sequencer: a behavioural bit engine logs commands; expected transfers are
// derived from a queue model of the FIFO and the transfer rules.
module tb_i2c_write_sequencer;

  localparam logic [1:0] CmdStart = 2'b00;
  localparam logic [1:0] CmdStop  = 2'b01;
  localparam logic [1:0] CmdTx    = 2'b10;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] clocksPerCycle;
  logic        xferStart, xferAbort, wrValid;
  logic [6:0]  slaveAddr;
  logic [7:0]  byteCount, wrData;
  logic        wrReady, busy, done, nackError, cycleDone, i2cTransactionValid;
  logic [7:0]  bytesSent, i2cWriteData;
  logic [1:0]  i2cCommand;
  logic        i2cBusy, i2cWriteAck, i2cReadDataValid;
  logic [7:0]  i2cReadData;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  i2c_write_sequencer #(.FIFO_DEPTH(4)) dut (
    .clk                 (clk),
    .reset               (reset),
    .clocksPerCycle      (clocksPerCycle),
    .xferStart           (xferStart),
    .xferAbort           (xferAbort),
    .slaveAddr           (slaveAddr),
    .byteCount           (byteCount),
    .wrData              (wrData),
    .wrValid             (wrValid),
    .wrReady             (wrReady),
    .busy                (busy),
    .done                (done),
    .nackError           (nackError),
    .bytesSent           (bytesSent),
    .cycleDone           (cycleDone),
    .i2cCommand          (i2cCommand),
    .i2cWriteData        (i2cWriteData),
    .i2cTransactionValid (i2cTransactionValid),
    .i2cBusy             (i2cBusy),
    .i2cWriteAck         (i2cWriteAck),
    .i2cReadData         (i2cReadData),
    .i2cReadDataValid    (i2cReadDataValid)
  );

  // Behavioural bit engine: START/STOP last 4 ticks, TX 36 ticks with the ACK bit near the end.
  logic        eng_busy = 1'b0, eng_is_tx = 1'b0, eng_nack_now = 1'b0, rdv = 1'b0;
  logic [7:0]  rd = 8'h00;
  int          eng_left = 0, eng_tx_cnt = 0, eng_acc_total = 0, nack_k_r = -1;
  logic [9:0]  cmd_log[$];
  logic        eng_accept;

  assign eng_accept       = i2cTransactionValid && cycleDone && !eng_busy;
  assign i2cWriteAck      = eng_accept && (i2cCommand == CmdTx);
  assign i2cBusy          = eng_busy;
  assign i2cReadData      = rd;
  assign i2cReadDataValid = rdv;

  always @(posedge clk) begin
    if (reset) begin
      eng_busy <= 1'b0;
      eng_left <= 0;
      rdv      <= 1'b0;
    end else begin
      rdv <= 1'b0;
      if (eng_accept) begin
        if (i2cCommand == CmdStart) begin
          cmd_log.delete();
          eng_tx_cnt <= 0;
        end
        if (i2cCommand == CmdTx) begin
          eng_nack_now <= (eng_tx_cnt == nack_k_r);
          eng_tx_cnt   <= eng_tx_cnt + 1;
        end
        cmd_log.push_back({i2cCommand, (i2cCommand == CmdTx) ? i2cWriteData : 8'h00});
        eng_acc_total <= eng_acc_total + 1;
        eng_busy      <= 1'b1;
        eng_is_tx     <= (i2cCommand == CmdTx);
        eng_left      <= (i2cCommand == CmdTx) ? 36 : 4;
      end else if (eng_busy && cycleDone) begin
        if (eng_is_tx && eng_left == 2) begin
          rdv <= 1'b1;
          rd  <= {7'($urandom()), eng_nack_now};
        end
        if (eng_left == 1) eng_busy <= 1'b0;
        eng_left <= eng_left - 1;
      end
    end
  end

  logic [7:0] fifo_model[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b, output logic accepted);
    @(negedge clk);
    wrData   = b;
    wrValid  = 1'b1;
    accepted = wrReady;
    if (accepted) fifo_model.push_back(b);
    @(posedge clk);
    #1 wrValid = 1'b0;
  endtask

  task automatic measure_period(output int p);
    int guard = 0;
    @(negedge clk);
    while (!cycleDone && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    p = 0;
    do begin
      @(negedge clk);
      p++;
    end while (!cycleDone && p < 100);
  endtask

  // nack_k: index of the NACKed TX (0 = address, -1 = none); abort_byte: data byte after which
  // abort is seen; push_at: cycle at which push_val is pushed mid-transfer (0 = none).
  task automatic run_xfer(input string name, input logic [6:0] addr, input logic [7:0] cnt,
                          input int nack_k, input int abort_byte, input int push_at,
                          input logic [7:0] push_val);
    logic [9:0] exp_q[$];
    int         acc0, sent, done_cnt;
    logic       exp_nack, finished;
    logic [7:0] b;
    acc0 = eng_acc_total;
    @(negedge clk);
    slaveAddr = addr;
    byteCount = cnt;
    nack_k_r  = nack_k;
    xferStart = 1'b1;
    @(negedge clk);
    xferStart = 1'b0;
    check({name, "_valid_after_start"}, i2cTransactionValid, 1);
    check({name, "_busy_after_start"}, busy, 1);
    done_cnt = 0;
    finished = 1'b0;
    for (int cyc = 0; cyc < 20000 && !finished; cyc++) begin
      @(negedge clk);
      if (abort_byte >= 0 && (eng_acc_total - acc0) >= abort_byte + 3) xferAbort = 1'b1;
      if (push_at > 0 && cyc == push_at - 10) check({name, "_stall_valid"}, i2cTransactionValid, 0);
      if (push_at > 0 && cyc == push_at) begin
        wrData  = push_val;
        wrValid = 1'b1;
        if (wrReady) fifo_model.push_back(push_val);
      end
      if (push_at > 0 && cyc == push_at + 1) wrValid = 1'b0;
      if (done) begin
        done_cnt++;
        finished = 1'b1;
      end
    end
    if (!finished) check({name, "_timeout"}, 0, 1);
    @(negedge clk);
    xferAbort = 1'b0;
    check({name, "_done_one_cycle"}, done, 0);
    check({name, "_busy_cleared"}, busy, 0);

    exp_nack = 1'b0;
    sent     = 0;
    exp_q.push_back({CmdStart, 8'h00});
    exp_q.push_back({CmdTx, addr, 1'b0});
    if (nack_k == 0) begin
      exp_nack = 1'b1;
    end else begin
      for (int i = 0; i < int'(cnt); i++) begin
        b = fifo_model.pop_front();
        exp_q.push_back({CmdTx, b});
        if (nack_k == i + 1) begin
          exp_nack = 1'b1;
          break;
        end
        sent++;
        if (abort_byte == i) break;
      end
    end
    exp_q.push_back({CmdStop, 8'h00});

    check({name, "_cmd_count"}, cmd_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < cmd_log.size(); i++)
      check($sformatf("%s_cmd%0d", name, i), cmd_log[i], exp_q[i]);
    check({name, "_bytesSent"}, bytesSent, sent);
    check({name, "_nackError"}, nackError, exp_nack);
    check({name, "_done_pulses"}, done_cnt, 1);
  endtask

  initial begin
    int         p, acc0, guard, cnt, nk;
    logic       ok;
    reset          = 1'b1;
    clocksPerCycle = 16'd3;
    xferStart      = 1'b0;
    xferAbort      = 1'b0;
    slaveAddr      = 7'd0;
    byteCount      = 8'd0;
    wrData         = 8'd0;
    wrValid        = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_nack", nackError, 0);
    check("rst_bytes", bytesSent, 0);
    check("rst_tick", cycleDone, 0);
    check("rst_valid", i2cTransactionValid, 0);
    check("rst_cmd", i2cCommand, 0);
    check("rst_wdata", i2cWriteData, 0);
    check("rst_wrready", wrReady, 1);
    reset = 1'b0;

    measure_period(p);
    check("tick_period_3a", p, 3);
    measure_period(p);
    check("tick_period_3b", p, 3);

    push_byte(8'hA5, ok);
    push_byte(8'h3C, ok);
    run_xfer("basic", 7'h50, 8'd2, -1, -1, 0, 8'h00);

    push_byte(8'($urandom()), ok);
    push_byte(8'($urandom()), ok);
    run_xfer("addr_nack", 7'($urandom()), 8'd2, 0, -1, 0, 8'h00);
    run_xfer("retained", 7'($urandom()), 8'd2, -1, -1, 0, 8'h00);

    run_xfer("zero_len", 7'($urandom()), 8'd0, -1, -1, 0, 8'h00);
    run_xfer("underrun", 7'($urandom()), 8'd1, -1, -1, 200, 8'($urandom()));

    for (int i = 0; i < 4; i++) push_byte(8'($urandom()), ok);
    run_xfer("abort", 7'($urandom()), 8'd4, -1, 1, 0, 8'h00);

    for (int t = 0; t < 3; t++) begin
      cnt = $urandom_range(0, 4);
      while (fifo_model.size() < cnt) push_byte(8'($urandom()), ok);
      nk = int'($urandom_range(0, cnt + 1)) - 1;
      run_xfer($sformatf("rand%0d", t), 7'($urandom()), 8'(cnt), nk, -1, 0, 8'h00);
    end

    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    fifo_model.delete();
    for (int i = 0; i < 4; i++) begin
      push_byte(8'($urandom()), ok);
      check($sformatf("fill_push%0d", i), ok, 1);
    end
    #1;
    check("full_wrready", wrReady, 0);
    push_byte(8'h77, ok);
    check("fifth_refused", ok, 0);

    acc0 = eng_acc_total;
    @(negedge clk);
    slaveAddr = 7'($urandom());
    byteCount = 8'd4;
    nack_k_r  = -1;
    xferStart = 1'b1;
    @(negedge clk);
    xferStart = 1'b0;
    guard = 0;
    while ((eng_acc_total - acc0) < 2 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    check("reach_addr_tx", (eng_acc_total - acc0) >= 2, 1);
    repeat (20) @(negedge clk);
    check("midtx_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    fifo_model.delete();
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_nack", nackError, 0);
    check("mid_rst_bytes", bytesSent, 0);
    check("mid_rst_tick", cycleDone, 0);
    check("mid_rst_valid", i2cTransactionValid, 0);
    check("mid_rst_cmd", i2cCommand, 0);
    check("mid_rst_wdata", i2cWriteData, 0);
    check("mid_rst_wrready", wrReady, 1);

    clocksPerCycle = 16'd0;
    measure_period(p);
    measure_period(p);
    check("tick_period_zero", p, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
